ic0_bus_master: RTL and testbench
=================================

# ic0_bus_master

Single-outstanding initiator for the ic0 interconnect: accepts read/write commands on a valid/ready command port, drives one ic0 bus transaction per command toward the peripheral slaves (GPIO and peers), and returns the result on a valid/ready response port. It sits between a simple command source (debug bridge, boot sequencer, test driver) and the ic0 slave side. Read completion comes from the per-slave `rd_ready` strobes, with slave selection and a bounded timeout.

## Interface
Parameters:
- NUM_SLV, 4 — number of slave read-return lanes
- TIMEOUT, 16 — maximum cycles `rd_valid` stays asserted awaiting a ready; must be ≥1
- ERR_DATA, 32'hDEADBEEF — `rsp_rdata` value on any error

Ports (reset c_sys_rst, asynchronous, active-high; clock clk):
- clk  in  1  clock
- c_sys_rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when both high
- rsp_rdata  out  32  read data; 0 for writes, ERR_DATA on error
- rsp_err  out  1  misaligned, timeout, or multiple-ready error
- ic0_c_axi_mst_wr_valid  out  1  single-cycle write strobe
- ic0_c_axi_mst_rd_valid  out  1  read request, held until completion
- ic0_axi_mst_wr_addr  out  32  write address
- ic0_axi_mst_wr_data  out  32  write data
- ic0_axi_mst_rd_addr  out  32  read address
- ic0_c_axi_slv_rd_ready  in  NUM_SLV  per-slave read-ready
- ic0_axi_slv_rd_data  in  NUM_SLV*32  per-slave read data, lane i at [32*i+31:32*i]; X when its ready is low

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE: `cmd_ready`=1, combinational from the state register only.
  - On handshake, register addr/wdata/write.
  - If `cmd_addr[1:0]`≠0, go directly to RESP with err=1, rdata=ERR_DATA, and no bus activity.
  - Otherwise go to WRITE if `cmd_write`, else READ.
- WRITE:
  - `wr_valid`=1 for exactly one cycle, with wr_addr/wr_data stable.
  - The ic0 write has no acknowledge; the write always succeeds.
  - Next state RESP, err=0, rdata=0.
- READ:
  - `rd_valid`=1 and rd_addr stable every cycle in READ.
  - Each cycle, sample the `rd_ready` vector:
    - Exactly one bit set: capture that lane's data (other lanes masked, never propagate X); go to RESP, err=0.
    - More than one bit set: go to RESP, err=1, rdata=ERR_DATA.
    - No bit set: increment the wait counter. If the counter reaches TIMEOUT, go to RESP, err=1, rdata=ERR_DATA.
- RESP:
  - `rsp_valid`=1; rdata/err held stable until `rsp_ready`.
  - Then go to IDLE.
- Wait counter:
  - Width `$clog2(TIMEOUT+1)`.
  - Cleared on entry to READ; never wraps.
- `cmd_write` is ignored outside IDLE.

## Timing
- All bus-side and response outputs are registered.
- Reset value of every output is 0, except `cmd_ready`=1 (state IDLE).
- Write: command handshake at cycle T → `wr_valid` at T+1 only → `rsp_valid` from T+2.
- Read, same-cycle slave response (GPIO behaviour): handshake T → `rd_valid` at T+1, ready seen at T+1 → `rd_valid` low and `rsp_valid` high at T+2.
- Read with no ready: `rd_valid` high during T+1..T+TIMEOUT → `rsp_valid` with err at T+TIMEOUT+1.
- Misaligned: handshake T → `rsp_valid` at T+1; no bus strobes.
- `rsp_ready` already high when `rsp_valid` rises: response completes in that cycle; IDLE, `cmd_ready`=1, next cycle.
- Minimum command spacing: 3 cycles for write/read; 2 for misaligned.
- Reset asserted mid-transaction: `rd_valid`/`wr_valid`/`rsp_valid` drop asynchronously; state returns to IDLE; the pending command is lost with no response.

## Structure
- Package ic0_pkg:
  - state enum (IDLE, WRITE, READ, RESP)
  - IC0_AW=32, IC0_DW=32
  - default ERR_DATA constant
- Sub-module ic0_rd_resp_sel:
  - combinational one-hot check and masked mux over NUM_SLV lanes
  - outputs `any_ready`, `multi_ready`, `sel_data`

## Test plan
- Write 0x80030014 data 0x000000A5 → `wr_valid` one cycle with that addr/data; `rsp_valid` 2 cycles after handshake, err=0, rdata=0.
- Read 0x80030020; lane 0 asserts ready with data 0x0000003C in the same cycle → `rsp_rdata`=0x0000003C, err=0, `rsp_valid` at T+2, `rd_valid` high exactly one cycle.
- Read with all ready low, TIMEOUT=16 → `rd_valid` high 16 cycles; then rsp err=1, rdata=0xDEADBEEF.
- Read where lanes 1 and 2 assert ready together → err=1, rdata=0xDEADBEEF. Separately: lane 3 ready with other lanes' data=X → rdata equals lane 3 data, no X.
- Command addr 0x80030002 → rsp at T+1, err=1, no `wr_valid`/`rd_valid` pulse.
- Hold `rsp_ready` low 5 cycles → rsp stable and `cmd_ready`=0 throughout. Then assert reset during a subsequent READ → all valids 0 immediately, `cmd_ready`=1 after reset release.

Source files
------------

// File: rtl/ic0_pkg.sv
// Shared types and constants for the ic0 interconnect initiator.
// Holds the master FSM state encoding, bus widths and the default error word.
package ic0_pkg;

    localparam int IC0_AW = 32;
    localparam int IC0_DW = 32;

    localparam logic [IC0_DW-1:0] IC0_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } ic0_state_e;

    // ic0 transfers are word-only; any nonzero low address bit is rejected
    function automatic logic is_misaligned(input logic [IC0_AW-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ic0_rd_resp_sel.sv
// Read-return lane selector: flags any/multiple ready strobes and muxes the
// data of the ready lane, masking every other lane so X never propagates.
module ic0_rd_resp_sel
    import ic0_pkg::*;
#(
    parameter int NUM_SLV = 4
) (
    input  logic [NUM_SLV-1:0]        rd_ready,
    input  logic [NUM_SLV*IC0_DW-1:0] rd_data,
    output logic                      any_ready,
    output logic                      multi_ready,
    output logic [IC0_DW-1:0]         sel_data
);

    logic                any_s;
    logic                multi_s;
    logic [IC0_DW-1:0]   data_s;

    // AND-OR mux: a lane contributes only while its own ready is high
    always_comb begin
        any_s   = 1'b0;
        multi_s = 1'b0;
        data_s  = {IC0_DW{1'b0}};
        for (int i = 0; i < NUM_SLV; i++) begin
            multi_s = multi_s | (any_s & rd_ready[i]);
            any_s   = any_s | rd_ready[i];
            data_s  = data_s | (rd_data[IC0_DW*i +: IC0_DW] & {IC0_DW{rd_ready[i]}});
        end
    end

    assign any_ready   = any_s;
    assign multi_ready = multi_s;
    assign sel_data    = data_s;

endmodule

// File: rtl/ic0_bus_master.sv
// Single-outstanding ic0 initiator: one bus write or read per accepted command,
// result returned on a valid/ready response port with misalign/timeout errors.
module ic0_bus_master
    import ic0_pkg::*;
#(
    parameter int                NUM_SLV  = 4,
    parameter int                TIMEOUT  = 16,
    parameter logic [IC0_DW-1:0] ERR_DATA = IC0_ERR_DATA
) (
    input  logic                      clk,
    input  logic                      c_sys_rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [IC0_AW-1:0]         cmd_addr,
    input  logic [IC0_DW-1:0]         cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IC0_DW-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      ic0_c_axi_mst_wr_valid,
    output logic                      ic0_c_axi_mst_rd_valid,
    output logic [IC0_AW-1:0]         ic0_axi_mst_wr_addr,
    output logic [IC0_DW-1:0]         ic0_axi_mst_wr_data,
    output logic [IC0_AW-1:0]         ic0_axi_mst_rd_addr,
    input  logic [NUM_SLV-1:0]        ic0_c_axi_slv_rd_ready,
    input  logic [NUM_SLV*IC0_DW-1:0] ic0_axi_slv_rd_data
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    ic0_state_e          state_r;
    ic0_state_e          state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic [IC0_AW-1:0]   addr_r;
    logic [IC0_DW-1:0]   wdata_r;
    logic [IC0_DW-1:0]   rsp_rdata_r;
    logic [IC0_DW-1:0]   rsp_rdata_nxt_s;
    logic                rsp_err_r;
    logic                rsp_err_nxt_s;
    logic                wr_valid_r;
    logic                rd_valid_r;
    logic                rsp_valid_r;
    logic                cmd_fire_s;
    logic                any_ready_s;
    logic                multi_ready_s;
    logic [IC0_DW-1:0]   sel_data_s;

    ic0_rd_resp_sel #(
        .NUM_SLV (NUM_SLV)
    ) u_rd_resp_sel (
        .rd_ready    (ic0_c_axi_slv_rd_ready),
        .rd_data     (ic0_axi_slv_rd_data),
        .any_ready   (any_ready_s),
        .multi_ready (multi_ready_s),
        .sel_data    (sel_data_s)
    );

    assign cmd_ready  = (state_r == IDLE);
    assign cmd_fire_s = cmd_valid & (state_r == IDLE);
    assign cnt_inc_s  = cnt_r + CNT_W'(1);

    // Next-state, wait counter and response word selection
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        rsp_rdata_nxt_s = rsp_rdata_r;
        rsp_err_nxt_s   = rsp_err_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    if (is_misaligned(cmd_addr)) begin
                        state_nxt_s     = RESP;
                        rsp_err_nxt_s   = 1'b1;
                        rsp_rdata_nxt_s = ERR_DATA;
                    end else if (cmd_write) begin
                        state_nxt_s = WRITE;
                    end else begin
                        state_nxt_s = READ;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITE: begin
                // ic0 writes are posted with no acknowledge
                state_nxt_s     = RESP;
                rsp_err_nxt_s   = 1'b0;
                rsp_rdata_nxt_s = {IC0_DW{1'b0}};
            end
            READ: begin
                if (multi_ready_s) begin
                    state_nxt_s     = RESP;
                    rsp_err_nxt_s   = 1'b1;
                    rsp_rdata_nxt_s = ERR_DATA;
                end else if (any_ready_s) begin
                    state_nxt_s     = RESP;
                    rsp_err_nxt_s   = 1'b0;
                    rsp_rdata_nxt_s = sel_data_s;
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    state_nxt_s     = RESP;
                    rsp_err_nxt_s   = 1'b1;
                    rsp_rdata_nxt_s = ERR_DATA;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counter and registered strobes; strobes follow the next state so
    // they are active exactly while the FSM sits in the matching state
    always_ff @(posedge clk or posedge c_sys_rst) begin
        if (c_sys_rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            rsp_rdata_r <= {IC0_DW{1'b0}};
            rsp_err_r   <= 1'b0;
            wr_valid_r  <= 1'b0;
            rd_valid_r  <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            wr_valid_r  <= (state_nxt_s == WRITE);
            rd_valid_r  <= (state_nxt_s == READ);
            rsp_valid_r <= (state_nxt_s == RESP);
        end
    end

    // Command capture; held for the whole bus transaction
    always_ff @(posedge clk or posedge c_sys_rst) begin
        if (c_sys_rst) begin
            addr_r  <= {IC0_AW{1'b0}};
            wdata_r <= {IC0_DW{1'b0}};
        end else if (cmd_fire_s) begin
            addr_r  <= cmd_addr;
            wdata_r <= cmd_wdata;
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    assign rsp_valid              = rsp_valid_r;
    assign rsp_rdata              = rsp_rdata_r;
    assign rsp_err                = rsp_err_r;
    assign ic0_c_axi_mst_wr_valid = wr_valid_r;
    assign ic0_c_axi_mst_rd_valid = rd_valid_r;
    assign ic0_axi_mst_wr_addr    = addr_r;
    assign ic0_axi_mst_wr_data    = wdata_r;
    assign ic0_axi_mst_rd_addr    = addr_r;

endmodule

// File: tb/tb_ic0_bus_master.sv
// Directed self-checking bench for ic0_bus_master: write, read, timeout,
// multi-ready, lane masking, misalignment, response backpressure and reset.
module tb_ic0_bus_master;

    localparam int NUM_SLV = 4;
    localparam int TIMEOUT = 16;

    logic                    clk = 1'b0;
    logic                    c_sys_rst;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [31:0]             cmd_addr;
    logic [31:0]             cmd_wdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [31:0]             rsp_rdata;
    logic                    rsp_err;
    logic                    wr_valid;
    logic                    rd_valid;
    logic [31:0]             wr_addr;
    logic [31:0]             wr_data;
    logic [31:0]             rd_addr;
    logic [NUM_SLV-1:0]      slv_rd_ready;
    logic [NUM_SLV*32-1:0]   slv_rd_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ic0_bus_master #(
        .NUM_SLV  (NUM_SLV),
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk                    (clk),
        .c_sys_rst              (c_sys_rst),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_write              (cmd_write),
        .cmd_addr               (cmd_addr),
        .cmd_wdata              (cmd_wdata),
        .rsp_valid              (rsp_valid),
        .rsp_ready              (rsp_ready),
        .rsp_rdata              (rsp_rdata),
        .rsp_err                (rsp_err),
        .ic0_c_axi_mst_wr_valid (wr_valid),
        .ic0_c_axi_mst_rd_valid (rd_valid),
        .ic0_axi_mst_wr_addr    (wr_addr),
        .ic0_axi_mst_wr_data    (wr_data),
        .ic0_axi_mst_rd_addr    (rd_addr),
        .ic0_c_axi_slv_rd_ready (slv_rd_ready),
        .ic0_axi_slv_rd_data    (slv_rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one cycle; returns at cycle T+1
    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        chk("cmd_ready_at_issue", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
    endtask

    task automatic set_lane(input int i, input logic [31:0] v);
        slv_rd_data[32*i +: 32] = v;
    endtask

    initial begin
        int hi_cnt;
        int rsp_at;
        int stray;

        c_sys_rst    = 1'b1;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_addr     = 32'd0;
        cmd_wdata    = 32'd0;
        rsp_ready    = 1'b1;
        slv_rd_ready = 4'b0000;
        slv_rd_data  = {(NUM_SLV*32){1'b1}};
        step();
        step();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_wr_valid",  {31'd0, wr_valid},  32'd0);
        chk("rst_rd_valid",  {31'd0, rd_valid},  32'd0);
        chk("rst_rdata",     rsp_rdata,          32'd0);
        chk("rst_err",       {31'd0, rsp_err},   32'd0);
        chk("rst_wr_addr",   wr_addr,            32'd0);
        c_sys_rst = 1'b0;
        step();

        // Write: strobe at T+1 only, response at T+2
        send(1'b1, 32'h8003_0014, 32'h0000_00A5);
        chk("wr_valid_t1", {31'd0, wr_valid}, 32'd1);
        chk("wr_addr_t1",  wr_addr,           32'h8003_0014);
        chk("wr_data_t1",  wr_data,           32'h0000_00A5);
        chk("wr_rdv_t1",   {31'd0, rd_valid}, 32'd0);
        chk("wr_rsp_t1",   {31'd0, rsp_valid}, 32'd0);
        step();
        chk("wr_valid_t2", {31'd0, wr_valid},  32'd0);
        chk("wr_rsp_t2",   {31'd0, rsp_valid}, 32'd1);
        chk("wr_err",      {31'd0, rsp_err},   32'd0);
        chk("wr_rdata",    rsp_rdata,          32'd0);
        step();
        chk("wr_done_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("wr_done_rdy", {31'd0, cmd_ready}, 32'd1);

        // Read, lane 0 answers in the same cycle rd_valid rises
        set_lane(0, 32'h0000_003C);
        send(1'b0, 32'h8003_0020, 32'd0);
        chk("rd0_valid_t1", {31'd0, rd_valid}, 32'd1);
        chk("rd0_addr_t1",  rd_addr,           32'h8003_0020);
        slv_rd_ready = 4'b0001;
        step();
        slv_rd_ready = 4'b0000;
        chk("rd0_valid_t2", {31'd0, rd_valid},  32'd0);
        chk("rd0_rsp_t2",   {31'd0, rsp_valid}, 32'd1);
        chk("rd0_rdata",    rsp_rdata,          32'h0000_003C);
        chk("rd0_err",      {31'd0, rsp_err},   32'd0);
        step();
        chk("rd0_done_rdy", {31'd0, cmd_ready}, 32'd1);

        // Read timeout: rd_valid for TIMEOUT cycles, error at T+TIMEOUT+1
        send(1'b0, 32'h8003_0040, 32'd0);
        hi_cnt = 0;
        rsp_at = 0;
        for (int k = 1; k <= 40; k++) begin
            if (rsp_valid) begin
                rsp_at = k;
                break;
            end
            if (rd_valid) hi_cnt++;
            step();
        end
        chk("to_rd_cycles", hi_cnt, TIMEOUT);
        chk("to_rsp_cycle", rsp_at, TIMEOUT + 1);
        chk("to_err",       {31'd0, rsp_err}, 32'd1);
        chk("to_rdata",     rsp_rdata,        32'hDEAD_BEEF);
        step();

        // Lanes 1 and 2 ready together
        set_lane(1, 32'h1111_1111);
        set_lane(2, 32'h2222_2222);
        send(1'b0, 32'h8003_0024, 32'd0);
        slv_rd_ready = 4'b0110;
        step();
        slv_rd_ready = 4'b0000;
        chk("multi_rsp",   {31'd0, rsp_valid}, 32'd1);
        chk("multi_err",   {31'd0, rsp_err},   32'd1);
        chk("multi_rdata", rsp_rdata,          32'hDEAD_BEEF);
        step();

        // Lane 3 alone; other lanes carry junk that must be masked
        set_lane(0, 32'hxxxx_xxxx);
        set_lane(1, 32'hFFFF_FFFF);
        set_lane(2, 32'hFFFF_FFFF);
        set_lane(3, 32'h1234_5678);
        send(1'b0, 32'h8003_0028, 32'd0);
        slv_rd_ready = 4'b1000;
        step();
        slv_rd_ready = 4'b0000;
        chk("ln3_rdata", rsp_rdata,        32'h1234_5678);
        chk("ln3_err",   {31'd0, rsp_err}, 32'd0);
        chk("ln3_no_x",  {31'd0, $isunknown(rsp_rdata)}, 32'd0);
        step();

        // Misaligned: response at T+1, no bus strobe
        send(1'b1, 32'h8003_0002, 32'h0000_0055);
        chk("mis_rsp_t1",  {31'd0, rsp_valid}, 32'd1);
        chk("mis_err",     {31'd0, rsp_err},   32'd1);
        chk("mis_rdata",   rsp_rdata,          32'hDEAD_BEEF);
        chk("mis_wrv",     {31'd0, wr_valid},  32'd0);
        chk("mis_rdv",     {31'd0, rd_valid},  32'd0);
        step();
        chk("mis_done_rdy", {31'd0, cmd_ready}, 32'd1);
        chk("mis_done_wrv", {31'd0, wr_valid},  32'd0);

        // Response backpressure for 5 cycles
        rsp_ready = 1'b0;
        set_lane(2, 32'hCAFE_0001);
        send(1'b0, 32'h8003_002C, 32'd0);
        slv_rd_ready = 4'b0100;
        step();
        slv_rd_ready = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata",     rsp_rdata,          32'hCAFE_0001);
            chk("bp_err",       {31'd0, rsp_err},   32'd0);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        chk("bp_still_valid", {31'd0, rsp_valid}, 32'd1);
        step();
        chk("bp_done_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("bp_done_rdy", {31'd0, cmd_ready}, 32'd1);

        // Reset during a pending read
        send(1'b0, 32'h8003_0030, 32'd0);
        step();
        chk("rr_rdv_before", {31'd0, rd_valid}, 32'd1);
        c_sys_rst = 1'b1;
        #1;
        chk("rr_rdv_async", {31'd0, rd_valid},  32'd0);
        chk("rr_wrv_async", {31'd0, wr_valid},  32'd0);
        chk("rr_rsp_async", {31'd0, rsp_valid}, 32'd0);
        step();
        c_sys_rst = 1'b0;
        step();
        chk("rr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid || rd_valid || wr_valid) stray++;
            step();
        end
        chk("rr_no_stray", stray, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
